// File: rtl/l1_mem_port_arbiter_pkg.sv
// Shared constants and types for the L1 memory port arbiter.
// Build option: MIST1032ISA_MEM_ARB_DATA_PRIORITY_EN (IDLE ties always go to DATA).
package l1_mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_OWN_INST = 2'd1;
  localparam logic [1:0] ST_OWN_DATA = 2'd2;

  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_AW     = 4;
  localparam int BURST_LIMIT = 8;

  localparam logic [FIFO_AW:0] FIFO_FULL_CNT = 5'd16;
  localparam logic [2:0]       BURST_LAST    = 3'd7;

  typedef struct packed {
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [13:0] asid;
    logic [1:0]  mmumod;
    logic [2:0]  mmups;
    logic [31:0] pdt;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_req_t;

  function automatic logic [1:0] owner_state(input logic tag);
    return (tag == TAG_DATA) ? ST_OWN_DATA : ST_OWN_INST;
  endfunction

endpackage

// File: rtl/l1_mem_port_arbiter_tag_fifo.sv
// 16x1 tag FIFO recording which requester owns each outstanding memory beat.
// A push while full is taken only when a pop happens in the same cycle.
module mem_arb_tag_fifo
  import l1_mem_port_arbiter_pkg::*;
(
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  logic [FIFO_DEPTH-1:0] tag_mem_reg;
  logic [FIFO_AW-1:0]    wr_ptr_reg;
  logic [FIFO_AW-1:0]    rd_ptr_reg;
  logic [FIFO_AW:0]      count_reg;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count_reg == FIFO_FULL_CNT);
  assign empty   = (count_reg == 5'd0);
  assign head    = tag_mem_reg[rd_ptr_reg];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge iCLOCK) begin
    if (push_ok) begin
      tag_mem_reg[wr_ptr_reg] <= push_tag;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_reg <= 4'd0;
      rd_ptr_reg <= 4'd0;
      count_reg  <= 5'd0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 4'd1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 4'd1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 5'd1;
        2'b01:   count_reg <= count_reg - 5'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/l1_mem_port_arbiter.sv
// Two-requester (INST/DATA) arbiter for one shared memory port with 8-beat bursts
// and in-order response routing. Build option: MIST1032ISA_MEM_ARB_DATA_PRIORITY_EN.
module l1_mem_port_arbiter
  import l1_mem_port_arbiter_pkg::*;
(
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iINST_REQ,
  output logic        oINST_LOCK,
  input  logic [1:0]  iINST_ORDER,
  input  logic [3:0]  iINST_MASK,
  input  logic        iINST_RW,
  input  logic [13:0] iINST_ASID,
  input  logic [1:0]  iINST_MMUMOD,
  input  logic [2:0]  iINST_MMUPS,
  input  logic [31:0] iINST_PDT,
  input  logic [31:0] iINST_ADDR,
  input  logic [31:0] iINST_DATA,
  output logic        oINST_VALID,
  output logic [23:0] oINST_MMU_FLAGS,
  output logic [63:0] oINST_RDATA,
  input  logic        iDATA_REQ,
  output logic        oDATA_LOCK,
  input  logic [1:0]  iDATA_ORDER,
  input  logic [3:0]  iDATA_MASK,
  input  logic        iDATA_RW,
  input  logic [13:0] iDATA_ASID,
  input  logic [1:0]  iDATA_MMUMOD,
  input  logic [2:0]  iDATA_MMUPS,
  input  logic [31:0] iDATA_PDT,
  input  logic [31:0] iDATA_ADDR,
  input  logic [31:0] iDATA_DATA,
  output logic        oDATA_VALID,
  output logic [23:0] oDATA_MMU_FLAGS,
  output logic [63:0] oDATA_RDATA,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic [1:0]  oMEM_ORDER,
  output logic [3:0]  oMEM_MASK,
  output logic        oMEM_RW,
  output logic [13:0] oMEM_ASID,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [2:0]  oMEM_MMUPS,
  output logic [31:0] oMEM_PDT,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic [23:0] iMEM_MMU_FLAGS,
  input  logic [63:0] iMEM_DATA,
  output logic        oARB_ERR
);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [2:0] burst_cnt_reg;
  logic [2:0] burst_cnt_next;
  logic       last_served_reg;
  logic       last_served_next;
  logic       arb_err_reg;

  logic       tie_tag;
  logic       grant_valid;
  logic       grant_tag;
  logic       granted_req;
  logic       other_req;
  logic       push_room;
  logic       mem_req;
  logic       accept;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_head;
  logic       fifo_pop;
  logic [1:0] grant_vec;
  logic [1:0] lock_vec;
  logic [1:0] valid_vec;
  mem_req_t   inst_fields;
  mem_req_t   data_fields;
  mem_req_t   sel_fields;

`ifdef MIST1032ISA_MEM_ARB_DATA_PRIORITY_EN
  assign tie_tag = TAG_DATA;
`else
  assign tie_tag = ~last_served_reg;
`endif

  always_comb begin
    grant_valid = 1'b0;
    grant_tag   = TAG_INST;
    case (state_reg)
      ST_OWN_INST: begin
        grant_valid = 1'b1;
        grant_tag   = TAG_INST;
      end
      ST_OWN_DATA: begin
        grant_valid = 1'b1;
        grant_tag   = TAG_DATA;
      end
      default: begin
        if (iINST_REQ && iDATA_REQ) begin
          grant_valid = 1'b1;
          grant_tag   = tie_tag;
        end else if (iINST_REQ) begin
          grant_valid = 1'b1;
          grant_tag   = TAG_INST;
        end else if (iDATA_REQ) begin
          grant_valid = 1'b1;
          grant_tag   = TAG_DATA;
        end
      end
    endcase
  end

  assign granted_req = (grant_tag == TAG_DATA) ? iDATA_REQ : iINST_REQ;
  assign other_req   = (grant_tag == TAG_DATA) ? iINST_REQ : iDATA_REQ;
  assign fifo_pop    = iMEM_VALID && !fifo_empty;
  // A full FIFO still takes a beat when a response frees a slot this cycle.
  assign push_room   = !fifo_full || fifo_pop;
  assign mem_req     = inRESET && grant_valid && granted_req && push_room;
  assign accept      = mem_req && !iMEM_LOCK;
  assign grant_vec   = {grant_valid && (grant_tag == TAG_DATA),
                        grant_valid && (grant_tag == TAG_INST)};

  always_comb begin
    state_next       = state_reg;
    burst_cnt_next   = burst_cnt_reg;
    last_served_next = last_served_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next     = owner_state(grant_tag);
          burst_cnt_next = 3'd1;
        end
      end
      ST_OWN_INST, ST_OWN_DATA: begin
        if (!granted_req) begin
          state_next       = ST_IDLE;
          burst_cnt_next   = 3'd0;
          last_served_next = grant_tag;
        end else if (accept) begin
          // Counter wraps to 0 on the 8th beat; ownership only yields if contended.
          burst_cnt_next = burst_cnt_reg + 3'd1;
          if ((burst_cnt_reg == BURST_LAST) && other_req) begin
            state_next       = ST_IDLE;
            burst_cnt_next   = 3'd0;
            last_served_next = grant_tag;
          end
        end
      end
      default: begin
        state_next     = ST_IDLE;
        burst_cnt_next = 3'd0;
      end
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_reg       <= ST_IDLE;
      burst_cnt_reg   <= 3'd0;
      last_served_reg <= TAG_INST;
      arb_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      burst_cnt_reg   <= burst_cnt_next;
      last_served_reg <= last_served_next;
      if (iMEM_VALID && fifo_empty) begin
        arb_err_reg <= 1'b1;
      end
    end
  end

  mem_arb_tag_fifo u_tag_fifo (
    .iCLOCK   (iCLOCK),
    .inRESET  (inRESET),
    .push     (accept),
    .push_tag (grant_tag),
    .pop      (iMEM_VALID),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign lock_vec[gi]  = !inRESET || iMEM_LOCK || !grant_vec[gi] || !push_room;
    assign valid_vec[gi] = inRESET && fifo_pop && (fifo_head == 1'(gi));
  end

  assign inst_fields = '{order: iINST_ORDER, mask: iINST_MASK, rw: iINST_RW,
                         asid: iINST_ASID, mmumod: iINST_MMUMOD, mmups: iINST_MMUPS,
                         pdt: iINST_PDT, addr: iINST_ADDR, data: iINST_DATA};
  assign data_fields = '{order: iDATA_ORDER, mask: iDATA_MASK, rw: iDATA_RW,
                         asid: iDATA_ASID, mmumod: iDATA_MMUMOD, mmups: iDATA_MMUPS,
                         pdt: iDATA_PDT, addr: iDATA_ADDR, data: iDATA_DATA};
  assign sel_fields  = (grant_tag == TAG_DATA) ? data_fields : inst_fields;

  assign oMEM_REQ    = mem_req;
  assign oMEM_ORDER  = sel_fields.order;
  assign oMEM_MASK   = sel_fields.mask;
  assign oMEM_RW     = sel_fields.rw;
  assign oMEM_ASID   = sel_fields.asid;
  assign oMEM_MMUMOD = sel_fields.mmumod;
  assign oMEM_MMUPS  = sel_fields.mmups;
  assign oMEM_PDT    = sel_fields.pdt;
  assign oMEM_ADDR   = sel_fields.addr;
  assign oMEM_DATA   = sel_fields.data;

  assign oINST_LOCK      = lock_vec[0];
  assign oDATA_LOCK      = lock_vec[1];
  assign oINST_VALID     = valid_vec[0];
  assign oDATA_VALID     = valid_vec[1];
  assign oINST_RDATA     = iMEM_DATA;
  assign oDATA_RDATA     = iMEM_DATA;
  assign oINST_MMU_FLAGS = iMEM_MMU_FLAGS;
  assign oDATA_MMU_FLAGS = iMEM_MMU_FLAGS;
  assign oARB_ERR        = arb_err_reg;

endmodule

// File: tb/tb_l1_mem_port_arbiter.sv
// Directed bench for l1_mem_port_arbiter: a queue-based behavioural model checked every
// cycle on the falling edge, plus literal expectations for each scenario.
module tb_l1_mem_port_arbiter;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iINST_REQ = 1'b0, iDATA_REQ = 1'b0;
  logic        oINST_LOCK, oDATA_LOCK;
  logic [1:0]  iINST_ORDER = 2'd2, iDATA_ORDER = 2'd1;
  logic [3:0]  iINST_MASK = 4'hF, iDATA_MASK = 4'h3;
  logic        iINST_RW = 1'b1, iDATA_RW = 1'b0;
  logic [13:0] iINST_ASID = 14'h0A5, iDATA_ASID = 14'h15A;
  logic [1:0]  iINST_MMUMOD = 2'd1, iDATA_MMUMOD = 2'd2;
  logic [2:0]  iINST_MMUPS = 3'd3, iDATA_MMUPS = 3'd5;
  logic [31:0] iINST_PDT = 32'h1111_0000, iDATA_PDT = 32'h2222_0000;
  logic [31:0] iINST_ADDR = 32'h0, iDATA_ADDR = 32'h0;
  logic [31:0] iINST_DATA = 32'hAAAA_0001, iDATA_DATA = 32'hBBBB_0002;
  logic        oINST_VALID, oDATA_VALID;
  logic [23:0] oINST_MMU_FLAGS, oDATA_MMU_FLAGS;
  logic [63:0] oINST_RDATA, oDATA_RDATA;
  logic        oMEM_REQ;
  logic        iMEM_LOCK = 1'b0;
  logic [1:0]  oMEM_ORDER;
  logic [3:0]  oMEM_MASK;
  logic        oMEM_RW;
  logic [13:0] oMEM_ASID;
  logic [1:0]  oMEM_MMUMOD;
  logic [2:0]  oMEM_MMUPS;
  logic [31:0] oMEM_PDT, oMEM_ADDR, oMEM_DATA;
  logic        iMEM_VALID = 1'b0;
  logic [23:0] iMEM_MMU_FLAGS = 24'h0;
  logic [63:0] iMEM_DATA = 64'h0;
  logic        oARB_ERR;

  l1_mem_port_arbiter dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iINST_REQ(iINST_REQ), .oINST_LOCK(oINST_LOCK), .iINST_ORDER(iINST_ORDER),
    .iINST_MASK(iINST_MASK), .iINST_RW(iINST_RW), .iINST_ASID(iINST_ASID),
    .iINST_MMUMOD(iINST_MMUMOD), .iINST_MMUPS(iINST_MMUPS), .iINST_PDT(iINST_PDT),
    .iINST_ADDR(iINST_ADDR), .iINST_DATA(iINST_DATA), .oINST_VALID(oINST_VALID),
    .oINST_MMU_FLAGS(oINST_MMU_FLAGS), .oINST_RDATA(oINST_RDATA),
    .iDATA_REQ(iDATA_REQ), .oDATA_LOCK(oDATA_LOCK), .iDATA_ORDER(iDATA_ORDER),
    .iDATA_MASK(iDATA_MASK), .iDATA_RW(iDATA_RW), .iDATA_ASID(iDATA_ASID),
    .iDATA_MMUMOD(iDATA_MMUMOD), .iDATA_MMUPS(iDATA_MMUPS), .iDATA_PDT(iDATA_PDT),
    .iDATA_ADDR(iDATA_ADDR), .iDATA_DATA(iDATA_DATA), .oDATA_VALID(oDATA_VALID),
    .oDATA_MMU_FLAGS(oDATA_MMU_FLAGS), .oDATA_RDATA(oDATA_RDATA),
    .oMEM_REQ(oMEM_REQ), .iMEM_LOCK(iMEM_LOCK), .oMEM_ORDER(oMEM_ORDER),
    .oMEM_MASK(oMEM_MASK), .oMEM_RW(oMEM_RW), .oMEM_ASID(oMEM_ASID),
    .oMEM_MMUMOD(oMEM_MMUMOD), .oMEM_MMUPS(oMEM_MMUPS), .oMEM_PDT(oMEM_PDT),
    .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA), .iMEM_VALID(iMEM_VALID),
    .iMEM_MMU_FLAGS(iMEM_MMU_FLAGS), .iMEM_DATA(iMEM_DATA), .oARB_ERR(oARB_ERR)
  );

  always #5 iCLOCK = ~iCLOCK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue of outstanding tags (0=INST, 1=DATA), owner (-1 = none), beats in burst.
  int  tag_q[$];
  int  owner = -1;
  int  beats = 0;
  int  last = 0;
  bit  err_m = 1'b0;
  int  grant_log[$];
  int  valid_log[$];

  always @(negedge iCLOCK) begin
    int win;
    bit can_push, exp_req, acc, hv;
    bit reqs [2];
    logic [121:0] inst_f, data_f, dut_f;
    if (!inRESET) begin
      chk("rst_mem_req", oMEM_REQ, 1'b0);
      chk("rst_inst_lock", oINST_LOCK, 1'b1);
      chk("rst_data_lock", oDATA_LOCK, 1'b1);
      chk("rst_valids", {oINST_VALID, oDATA_VALID}, 2'b00);
      chk("rst_err", oARB_ERR, 1'b0);
      tag_q.delete();
      owner = -1; beats = 0; last = 0; err_m = 1'b0;
    end else begin
      reqs[0] = iINST_REQ;
      reqs[1] = iDATA_REQ;
      can_push = (tag_q.size() < 16) || iMEM_VALID;
      if (owner >= 0) win = owner;
      else if (reqs[0] && reqs[1]) begin
`ifdef MIST1032ISA_MEM_ARB_DATA_PRIORITY_EN
        win = 1;
`else
        win = 1 - last;
`endif
      end
      else if (reqs[0]) win = 0;
      else if (reqs[1]) win = 1;
      else win = -1;
      exp_req = (win >= 0) && reqs[win] && can_push;

      chk("mem_req", oMEM_REQ, exp_req);
      chk("inst_lock", oINST_LOCK, iMEM_LOCK || (win != 0) || !can_push);
      chk("data_lock", oDATA_LOCK, iMEM_LOCK || (win != 1) || !can_push);
      if (exp_req) begin
        inst_f = {iINST_ORDER, iINST_MASK, iINST_RW, iINST_ASID, iINST_MMUMOD,
                  iINST_MMUPS, iINST_PDT, iINST_ADDR, iINST_DATA};
        data_f = {iDATA_ORDER, iDATA_MASK, iDATA_RW, iDATA_ASID, iDATA_MMUMOD,
                  iDATA_MMUPS, iDATA_PDT, iDATA_ADDR, iDATA_DATA};
        dut_f  = {oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_ASID, oMEM_MMUMOD,
                  oMEM_MMUPS, oMEM_PDT, oMEM_ADDR, oMEM_DATA};
        chk("mem_fields", dut_f, (win == 1) ? data_f : inst_f);
      end
      hv = iMEM_VALID && (tag_q.size() > 0);
      chk("inst_valid", oINST_VALID, hv && (tag_q[0] == 0));
      chk("data_valid", oDATA_VALID, hv && (tag_q[0] == 1));
      if (hv && tag_q[0] == 0)
        chk("inst_rdata", {oINST_MMU_FLAGS, oINST_RDATA}, {iMEM_MMU_FLAGS, iMEM_DATA});
      if (hv && tag_q[0] == 1)
        chk("data_rdata", {oDATA_MMU_FLAGS, oDATA_RDATA}, {iMEM_MMU_FLAGS, iMEM_DATA});
      chk("arb_err", oARB_ERR, err_m);

      if (oMEM_REQ && !iMEM_LOCK) grant_log.push_back(!oDATA_LOCK ? 1 : 0);
      if (oINST_VALID) valid_log.push_back(0);
      if (oDATA_VALID) valid_log.push_back(1);

      acc = exp_req && !iMEM_LOCK;
      if (iMEM_VALID) begin
        if (tag_q.size() > 0) tag_q.delete(0);
        else err_m = 1'b1;
      end
      if (acc) tag_q.push_back(win);
      if (owner < 0) begin
        if (acc) begin owner = win; beats = 1; end
      end else if (!reqs[owner]) begin
        last = owner; owner = -1;
      end else if (acc) begin
        beats++;
        if (beats == 8) begin
          beats = 0;
          if (reqs[1 - owner]) begin last = owner; owner = -1; end
        end
      end
    end
  end

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic do_reset();
    inRESET = 1'b0;
    tick();
    tick();
    inRESET = 1'b1;
    tick();
  endtask

  function automatic int count_of(input int q[$], input int v);
    int n = 0;
    foreach (q[k]) if (q[k] == v) n++;
    return n;
  endfunction

  function automatic logic [15:0] pack16(input int q[$]);
    logic [15:0] b = '0;
    foreach (q[k]) if (k < 16 && q[k] == 1) b[k] = 1'b1;
    return b;
  endfunction

  initial begin
    repeat (3) tick();
    inRESET = 1'b1;
    tick();

    // Single DATA requester: 8 beats, 8 responses
    grant_log.delete(); valid_log.delete();
    iDATA_REQ = 1'b1; iDATA_RW = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iDATA_ADDR = 32'h1000 + 32'(i * 4);
      tick();
    end
    iDATA_REQ = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      iMEM_VALID = 1'b1; iMEM_DATA = {32'hCAFE_0000, 32'(i)}; iMEM_MMU_FLAGS = 24'(i + 7);
      tick();
    end
    iMEM_VALID = 1'b0;
    tick();
    chk("t1_beats", grant_log.size(), 8);
    chk("t1_data_beats", count_of(grant_log, 1), 8);
    chk("t1_data_valids", count_of(valid_log, 1), 8);
    chk("t1_inst_valids", count_of(valid_log, 0), 0);
    $display("[TB] single DATA burst: %0d beats, %0d responses", grant_log.size(), valid_log.size());

    // Both requesters from reset: DATA gets 8, then INST gets 8
    do_reset();
    grant_log.delete(); valid_log.delete();
    iDATA_RW = 1'b0;
    iINST_REQ = 1'b1; iDATA_REQ = 1'b1;
    iINST_ADDR = 32'h2000; iDATA_ADDR = 32'h3000;
    for (int c = 0; c < 16; c++) begin
      iMEM_VALID = (c >= 3);
      iMEM_DATA = 64'(c);
      tick();
    end
    iINST_REQ = 1'b0; iDATA_REQ = 1'b0;
    iMEM_VALID = 1'b1;
    repeat (3) tick();
    iMEM_VALID = 1'b0;
    tick();
    chk("t2_grant_count", grant_log.size(), 16);
    chk("t2_grant_order", pack16(grant_log), 16'h00FF);
    chk("t2_valid_count", valid_log.size(), 16);
    chk("t2_valid_order", pack16(valid_log), 16'h00FF);
    $display("[TB] contended bursts: grants=%h responses=%h", pack16(grant_log), pack16(valid_log));

    // INST burst stalled by iMEM_LOCK; ownership must survive the stall
    grant_log.delete(); valid_log.delete();
    iINST_REQ = 1'b1;
    tick();
    tick();
    iMEM_LOCK = 1'b1; iDATA_REQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_inst_lock", oINST_LOCK, 1'b1);
      tick();
    end
    iMEM_LOCK = 1'b0;
    #1;
    chk("t3_still_inst", {oINST_LOCK, oDATA_LOCK}, 2'b01);
    tick();
    tick();
    iINST_REQ = 1'b0; iDATA_REQ = 1'b0;
    tick();
    iMEM_VALID = 1'b1;
    repeat (4) tick();
    iMEM_VALID = 1'b0;
    tick();
    chk("t3_beats", grant_log.size(), 4);
    chk("t3_inst_beats", count_of(grant_log, 0), 4);
    $display("[TB] locked INST burst: %0d beats", grant_log.size());

    // Fill the tag FIFO, then accept one beat alongside a response
    do_reset();
    grant_log.delete(); valid_log.delete();
    iDATA_REQ = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iDATA_ADDR = 32'h4000 + 32'(i * 4);
      tick();
    end
    #1;
    chk("t4_full_req", oMEM_REQ, 1'b0);
    chk("t4_full_locks", {oINST_LOCK, oDATA_LOCK}, 2'b11);
    tick();
    iMEM_VALID = 1'b1;
    #1;
    chk("t4_pushpop_req", oMEM_REQ, 1'b1);
    chk("t4_pushpop_lock", oDATA_LOCK, 1'b0);
    tick();
    iMEM_VALID = 1'b0;
    #1;
    chk("t4_still_full", oMEM_REQ, 1'b0);
    iDATA_REQ = 1'b0;
    tick();
    iMEM_VALID = 1'b1;
    repeat (16) tick();
    iMEM_VALID = 1'b0;
    tick();
    chk("t4_beats", grant_log.size(), 17);
    chk("t4_responses", valid_log.size(), 17);
    $display("[TB] FIFO full: %0d beats, %0d responses", grant_log.size(), valid_log.size());

    // Stray response with nothing outstanding
    iMEM_VALID = 1'b1;
    #1;
    chk("t5_no_valid", {oINST_VALID, oDATA_VALID}, 2'b00);
    tick();
    iMEM_VALID = 1'b0;
    #1;
    chk("t5_err_set", oARB_ERR, 1'b1);
    repeat (5) tick();
    chk("t5_err_held", oARB_ERR, 1'b1);
    $display("[TB] stray response: err=%0b", oARB_ERR);

    // Reset mid-burst with 3 tags outstanding
    iINST_REQ = 1'b1;
    repeat (3) tick();
    inRESET = 1'b0; iINST_REQ = 1'b0;
    #1;
    chk("t6_rst_req", oMEM_REQ, 1'b0);
    chk("t6_rst_locks", {oINST_LOCK, oDATA_LOCK}, 2'b11);
    chk("t6_rst_err", oARB_ERR, 1'b0);
    tick();
    inRESET = 1'b1;
    tick();
    iINST_REQ = 1'b1; iDATA_REQ = 1'b1;
    #1;
    chk("t6_tie_data", {oINST_LOCK, oDATA_LOCK}, 2'b10);
    tick();
    iINST_REQ = 1'b0; iDATA_REQ = 1'b0;
    tick();
    iMEM_VALID = 1'b1;
    #1;
    chk("t6_data_resp", oDATA_VALID, 1'b1);
    tick();
    #1;
    chk("t6_tags_dropped", {oINST_VALID, oDATA_VALID}, 2'b00);
    tick();
    iMEM_VALID = 1'b0;
    #1;
    chk("t6_err_after", oARB_ERR, 1'b1);
    tick();
    $display("[TB] reset mid-burst: err=%0b", oARB_ERR);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l1_mem_port_arbiter.md
L1_MEM_PORT_ARBITER -- requirements
Module: l1_mem_port_arbiter

Interface
REQ-001 The block SHALL have no parameters; FIFO depth 16 and burst limit 8 are fixed constants.
REQ-002 The block SHALL have ports iCLOCK, in, 1, the only clock, rising edge.
REQ-003 The block SHALL have ports inRESET, in, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports iINST_REQ / iDATA_REQ, in, 1, requester wants a memory beat issued.
REQ-005 The block SHALL have ports oINST_LOCK / oDATA_LOCK, out, 1, beat not accepted this cycle.
REQ-006 The block SHALL have ports iINST_ORDER / iDATA_ORDER, in, 2, access size.
REQ-007 The block SHALL have ports iINST_MASK / iDATA_MASK, in, 4, byte mask.
REQ-008 The block SHALL have ports iINST_RW / iDATA_RW, in, 1, 0 = write, 1 = read.
REQ-009 The block SHALL have ports iINST_ASID / iDATA_ASID, in, 14, address-space ID.
REQ-010 The block SHALL have ports iINST_MMUMOD / iDATA_MMUMOD, in, 2, MMU mode.
REQ-011 The block SHALL have ports iINST_MMUPS / iDATA_MMUPS, in, 3, page size.
REQ-012 The block SHALL have ports iINST_PDT / iDATA_PDT, in, 32, page directory table.
REQ-013 The block SHALL have ports iINST_ADDR / iDATA_ADDR, in, 32, address.
REQ-014 The block SHALL have ports iINST_DATA / iDATA_DATA, in, 32, write data.
REQ-015 The block SHALL have ports oINST_VALID / oDATA_VALID, out, 1, response beat for this requester.
REQ-016 The block SHALL have ports oINST_MMU_FLAGS / oDATA_MMU_FLAGS, out, 24, response flags.
REQ-017 The block SHALL have ports oINST_RDATA / oDATA_RDATA, out, 64, response data.
REQ-018 The block SHALL have ports oMEM_REQ, out, 1, and iMEM_LOCK, in, 1, shared memory request handshake.
REQ-019 The block SHALL have ports oMEM_ORDER/MASK/RW/ASID/MMUMOD/MMUPS/PDT/ADDR/DATA, out, widths as the requester fields, muxed request.
REQ-020 The block SHALL have ports iMEM_VALID, in, 1; iMEM_MMU_FLAGS, in, 24; iMEM_DATA, in, 64, in-order memory responses.
REQ-021 The block SHALL have port oARB_ERR, out, 1, sticky flag: response arrived with no outstanding beat.

Function
REQ-022 A beat SHALL be accepted when oMEM_REQ=1 and iMEM_LOCK=0 in the same cycle, with zero-cycle request latency.
REQ-023 oMEM_REQ SHALL equal the granted requester's REQ gated by tag FIFO not full, and all oMEM_* fields SHALL be combinationally muxed from the granted requester.
REQ-024 oX_LOCK SHALL equal iMEM_LOCK, or X not granted, or tag FIFO full.
REQ-025 The arbiter SHALL implement the states IDLE, OWN_INST and OWN_DATA.
REQ-026 In IDLE the grant SHALL be combinational: a single requester wins; on a tie the requester not served last wins (round-robin).
REQ-027 On the first accepted beat in IDLE, the state SHALL move to OWN_<winner> and the burst counter SHALL load 1.
REQ-028 In OWN_X the grant SHALL stay on X, and each accepted beat SHALL increment the 3-bit burst counter.
REQ-029 OWN_X SHALL return to IDLE when iX_REQ=0 in a cycle, or when the 8th beat is accepted while the other requester's REQ=1; the last-served pointer SHALL then be set to X.
REQ-030 When the 8th beat is accepted with the other requester idle, the counter SHALL wrap to 0 and ownership SHALL continue.
REQ-031 Each accepted beat SHALL push a 1-bit tag (0 = INST, 1 = DATA) into a 16-entry FIFO, and each iMEM_VALID SHALL pop it.
REQ-032 A simultaneous push and pop SHALL leave the FIFO count unchanged, and a push is allowed when full only if a pop occurs in the same cycle.
REQ-033 oX_VALID SHALL equal iMEM_VALID && FIFO nonempty && head tag == X, and oX_RDATA and oX_MMU_FLAGS SHALL pass iMEM_DATA and iMEM_MMU_FLAGS unregistered.
REQ-034 When iMEM_VALID arrives with the FIFO empty, the beat SHALL be dropped, neither valid SHALL assert, and oARB_ERR SHALL be set and held until reset.
REQ-035 Write beats SHALL be tagged and routed identically to reads, since memory returns a valid for writes.

Reset
REQ-036 Asserting inRESET SHALL asynchronously set the state to IDLE, the burst counter to 0, the FIFO to empty, the last-served pointer to INST (so DATA wins the first tie), and oARB_ERR to 0.
REQ-037 During reset oMEM_REQ, oINST_VALID and oDATA_VALID SHALL be 0 and both LOCK outputs SHALL be 1.
REQ-038 Reset mid-burst SHALL discard outstanding tags, and requesters SHALL be reset concurrently.

Configuration
REQ-039 With MIST1032ISA_MEM_ARB_DATA_PRIORITY_EN defined, IDLE ties SHALL always go to DATA, and the burst limit and all other behaviour SHALL be unchanged.
REQ-040 With MIST1032ISA_MEM_ARB_DATA_PRIORITY_EN undefined, IDLE ties SHALL use round-robin per REQ-026.

Structure
REQ-041 The shared package SHALL hold: state encodings, tag encodings (TAG_INST=0, TAG_DATA=1), FIFO depth 16, and burst limit 8.
REQ-042 A single sub-module mem_arb_tag_fifo SHALL implement the 16x1 FIFO with push, pop, full, empty and head outputs, using asynchronous active-low reset.

Verification
REQ-043 The bench SHALL drive only DATA_REQ, ADDR 0x1000, for 8 beats with iMEM_LOCK=0 -> 8 consecutive oMEM_REQ with ADDR following iDATA_ADDR, and 8 responses -> 8 oDATA_VALID and 0 oINST_VALID.
REQ-044 The bench SHALL drive both REQs from reset -> DATA owns the first 8 beats; then IDLE; INST owns next; the interleave of responses SHALL match the FIFO tag order.
REQ-045 The bench SHALL hold iMEM_LOCK=1 for 5 cycles during an INST burst -> no tag pushed, oINST_LOCK=1, and state remains OWN_INST.
REQ-046 The bench SHALL issue 16 beats with no responses -> FIFO full and both LOCKs=1; then one iMEM_VALID together with REQ -> the beat is accepted and the count stays 16.
REQ-047 The bench SHALL pulse iMEM_VALID with the FIFO empty -> no valid outputs and oARB_ERR=1 until inRESET.
REQ-048 The bench SHALL assert inRESET mid-burst with 3 tags outstanding -> FIFO empty, state IDLE, and the next tie goes to DATA.
